surf_rate_scaler: RTL and testbench
===================================

// Module: surf_rate_scaler
// PURPOSE
//  Consumes the kHz timebase from the scaler clock generator (khz_clk_i) and counts
//  rising edges on NCH trigger lines over a programmable gate of period_i kHz ticks.
//  At each gate end it latches all counts into a readout bank and pulses update_o.
//  The bank is read one channel at a time by the register/readout logic.
// PARAMETERS
//  NCH  12  trigger channels counted
//  CW   16  counter/readout width; counts saturate at 2^CW-1
//  PW   10  width of period_i (gate length, in kHz ticks)
//  SW = $clog2(NCH), derived localparam, width of sel_i
// PORTS
//  clk33_i      in   1    33 MHz system clock; all logic on rising edge
//  rst_n_i      in   1    asynchronous, active-low reset
//  khz_clk_i    in   1    kHz timebase level, clk33_i-synchronous; rising edge = 1 tick
//  trig_i       in   NCH  trigger levels, clk33_i-synchronous; rising edge = 1 count
//  enable_i     in   1    1 = run gates continuously
//  clear_i      in   1    abort current gate, zero live counters, no latch
//  period_i     in   PW   gate length in ticks; 0 treated as 1
//  sel_i        in   SW   readout channel select
//  rd_i         in   1    read strobe
//  dat_o        out  CW   latched count of channel sel_i
//  dat_valid_o  out  1    1-cycle pulse, 1 clk after rd_i
//  update_o     out  1    1-cycle pulse when a new bank is latched
//  overflow_o   out  NCH  per-channel saturation flag of the latched bank
// BEHAVIOUR
//  Reset: all outputs 0, live and latched counters 0, FSM IDLE, edge regs 0.
//  Edge detect: registered copy of khz_clk_i and trig_i; tick = cur & ~prev.
//   A level high out of reset is not an edge.
//  FSM IDLE -> ARM when enable_i=1. ARM -> COUNT on first tick (gate aligned to
//   timebase; live counters zeroed, period_i sampled into gate_len, tick_cnt=0).
//   COUNT: each tick increments tick_cnt; tick with tick_cnt==gate_len-1 -> LATCH.
//   LATCH (1 cycle): bank <= live, overflow_o <= live saturation flags,
//   update_o=1 during the next cycle; -> COUNT with a new gate (period_i resampled)
//   if enable_i=1, else IDLE.
//  Counting: live counters increment only in COUNT; saturate at 2^CW-1, set sat flag.
//   Trig edge in the LATCH cycle belongs to the new gate (live reloads to 1, not 0).
//   Trig edge coincident with the final tick is counted in the closing gate.
//  Timing: latched bank reflects edges in exactly gate_len tick intervals; update_o
//   asserts 2 clk after the final tick's rising edge on khz_clk_i.
//  clear_i: highest priority; any state -> ARM (or IDLE if enable_i=0), live counters
//   and tick_cnt zeroed, bank/overflow_o untouched, no update_o.
//  enable_i low mid-gate: -> IDLE at next clk, partial gate discarded, bank retained.
//  period_i changes mid-gate take effect at next gate start only.
//  Read: rd_i in cycle N -> dat_o=bank[sel_i], dat_valid_o=1 in cycle N+1. dat_o
//   holds between reads. sel_i>=NCH returns 0. rd_i in the LATCH cycle returns the
//   pre-update value.
// STRUCTURE
//  Shared package surf_scaler_pkg: FSM state encodings (IDLE/ARM/COUNT/LATCH), CW/PW
//   defaults, reused by the scaler readout register map.
//  Sub-module surf_scaler_chan (x NCH, generate loop): trig edge detect +
//   saturating counter + sat flag, controlled by run/reload/clear from the top FSM.
//  Top holds timebase edge detect, FSM, tick counter, latched bank, read mux.
// TESTING  (clk33 = 30 ns; khz_clk_i driven fast by bench, tick every 20 clk)
//  1 period_i=4, trig_i[0] pulses every 10 clk -> update_o every 80 clk after
//    first gate, bank[0]=8, other channels 0, overflow_o=0.
//  2 CW=4, trig_i[3] edge every 2 clk, period_i=4 -> bank[3]=15,
//    overflow_o[3]=1; next gate without trigs -> bank[3]=0, overflow_o[3]=0.
//  3 Trig edges on the final-tick cycle and on the LATCH cycle -> first counted in
//    closing gate, second in new gate; per-gate totals exact.
//  4 clear_i mid-gate after 5 edges -> no update_o for that gate, bank unchanged;
//    next full gate latches only post-clear edges.
//  5 rd_i with sel_i=2 in LATCH cycle -> old value; rd_i one clk later -> new value;
//    sel_i=13 (NCH=12) -> dat_o=0, dat_valid_o=1.
//  6 rst_n_i low mid-gate, asynchronously between edges -> outputs 0 immediately;
//    after release with khz_clk_i high, no spurious tick; period_i=0 gives 1-tick gates.

Source files
------------

// File: rtl/surf_scaler_pkg.sv
// surf_scaler_pkg: state encodings and width defaults shared by the
// SURF rate scaler and its readout register map.
package surf_scaler_pkg;

    localparam int NCH_DEF = 12;
    localparam int CW_DEF  = 16;
    localparam int PW_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_LATCH = 2'd3
    } scaler_state_t;

endpackage

// File: rtl/surf_scaler_chan.sv
// surf_scaler_chan: one trigger channel -- rising-edge detect feeding a
// saturating live counter with a sticky saturation flag.
module surf_scaler_chan
    import surf_scaler_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    input  logic          run,
    input  logic          reload,
    input  logic          zero,
    output logic [CW-1:0] count,
    output logic          sat
);

    localparam logic [CW-1:0] MAX = '1;

    logic trig_q;
    logic hit;

    assign hit = trig & ~trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
            count  <= '0;
            sat    <= 1'b0;
        end else begin
            trig_q <= trig;
            if (zero) begin
                count <= '0;
                sat   <= 1'b0;
            end else if (reload) begin
                // an edge in the latch cycle opens the new gate
                count <= CW'(hit);
                sat   <= 1'b0;
            end else if (run && hit) begin
                if (count == MAX)
                    sat <= 1'b1;
                else
                    count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/surf_rate_scaler.sv
// surf_rate_scaler: gates NCH trigger counters on the kHz timebase,
// latches each gate into a readout bank and serves channel reads.
module surf_rate_scaler
    import surf_scaler_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    parameter  int CW  = CW_DEF,
    parameter  int PW  = PW_DEF,
    localparam int SW  = $clog2(NCH)
) (
    input  logic           clk33_i,
    input  logic           rst_n_i,
    input  logic           khz_clk_i,
    input  logic [NCH-1:0] trig_i,
    input  logic           enable_i,
    input  logic           clear_i,
    input  logic [PW-1:0]  period_i,
    input  logic [SW-1:0]  sel_i,
    input  logic           rd_i,
    output logic [CW-1:0]  dat_o,
    output logic           dat_valid_o,
    output logic           update_o,
    output logic [NCH-1:0] overflow_o
);

    scaler_state_t  state;
    logic           khz_q;
    logic           primed;
    logic           tick;
    logic [PW-1:0]  gate_len;
    logic [PW-1:0]  tick_cnt;
    logic [PW-1:0]  next_len;
    logic [CW-1:0]  live [NCH];
    logic [CW-1:0]  bank [NCH];
    logic [NCH-1:0] sat;
    logic           zero_live;
    logic           reload_live;
    logic           run_live;

    // primed masks the first cycle so a level high out of reset is no tick
    assign tick        = khz_clk_i & ~khz_q & primed;
    assign next_len    = (period_i == '0) ? PW'(1) : period_i;
    assign zero_live   = clear_i | (state == ST_IDLE) | (state == ST_ARM);
    assign reload_live = (state == ST_LATCH);
    assign run_live    = (state == ST_COUNT);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        surf_scaler_chan #(.CW(CW)) u_chan (
            .clk    (clk33_i),
            .rst_n  (rst_n_i),
            .trig   (trig_i[i]),
            .run    (run_live),
            .reload (reload_live),
            .zero   (zero_live),
            .count  (live[i]),
            .sat    (sat[i])
        );
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            khz_q      <= 1'b0;
            primed     <= 1'b0;
            gate_len   <= '0;
            tick_cnt   <= '0;
            update_o   <= 1'b0;
            overflow_o <= '0;
            for (int i = 0; i < NCH; i++)
                bank[i] <= '0;
        end else begin
            khz_q    <= khz_clk_i;
            primed   <= 1'b1;
            update_o <= 1'b0;
            if (clear_i) begin
                state    <= enable_i ? ST_ARM : ST_IDLE;
                tick_cnt <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (enable_i)
                            state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (!enable_i) begin
                            state <= ST_IDLE;
                        end else if (tick) begin
                            state    <= ST_COUNT;
                            gate_len <= next_len;
                            tick_cnt <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (!enable_i) begin
                            state <= ST_IDLE;
                        end else if (tick) begin
                            if (tick_cnt == gate_len - 1'b1)
                                state <= ST_LATCH;
                            else
                                tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        for (int i = 0; i < NCH; i++)
                            bank[i] <= live[i];
                        overflow_o <= sat;
                        update_o   <= 1'b1;
                        if (enable_i) begin
                            state    <= ST_COUNT;
                            gate_len <= next_len;
                            tick_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // a read in the latch cycle sees the bank before it is overwritten
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
        end else begin
            dat_valid_o <= rd_i;
            if (rd_i)
                dat_o <= (int'(sel_i) < NCH) ? bank[sel_i] : '0;
        end
    end

endmodule

// File: tb/tb_surf_rate_scaler.sv
// Testbench for surf_rate_scaler: gating, saturation, gate boundaries,
// clear, readout timing and asynchronous reset.
module tb_surf_rate_scaler;

    localparam int NCH = 12;
    localparam int CW  = 16;
    localparam int PW  = 10;
    localparam int SW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           khz;
    logic [NCH-1:0] trig;
    logic           enable;
    logic           clear;
    logic           rd;
    logic [PW-1:0]  period;
    logic [SW-1:0]  sel;
    logic [CW-1:0]  dat;
    logic           dat_valid;
    logic           update;
    logic [NCH-1:0] overflow;
    logic [3:0]     dat4;
    logic           dat_valid4;
    logic           update4;
    logic [NCH-1:0] overflow4;

    int checks = 0;
    int passes = 0;
    int cyc;
    int phase;
    int mode;
    int n_upd;
    int last_upd;
    bit khz_on;

    always #15 clk = ~clk;

    surf_rate_scaler #(.NCH(NCH), .CW(CW), .PW(PW)) u_dut (
        .clk33_i     (clk),
        .rst_n_i     (rst_n),
        .khz_clk_i   (khz),
        .trig_i      (trig),
        .enable_i    (enable),
        .clear_i     (clear),
        .period_i    (period),
        .sel_i       (sel),
        .rd_i        (rd),
        .dat_o       (dat),
        .dat_valid_o (dat_valid),
        .update_o    (update),
        .overflow_o  (overflow)
    );

    surf_rate_scaler #(.NCH(NCH), .CW(4), .PW(PW)) u_dut4 (
        .clk33_i     (clk),
        .rst_n_i     (rst_n),
        .khz_clk_i   (khz),
        .trig_i      (trig),
        .enable_i    (enable),
        .clear_i     (clear),
        .period_i    (period),
        .sel_i       (sel),
        .rd_i        (rd),
        .dat_o       (dat4),
        .dat_valid_o (dat_valid4),
        .update_o    (update4),
        .overflow_o  (overflow4)
    );

    // trigger pattern per scenario, indexed by step number within the test
    function automatic logic [NCH-1:0] pat(input int m, input int k);
        logic [NCH-1:0] t;
        t = '0;
        case (m)
            1: t[0] = (k % 10 == 0);
            2: t[3] = (k % 2 == 0) && (k <= 100);
            3: begin
                t[1] = (k == 30) || (k == 60) || (k == 100);
                t[2] = (k == 61) || (k == 80) || (k == 101);
            end
            4: t[4] = ((k % 10 == 0) && (k >= 30) && (k <= 150))
                      || (k == 170) || (k == 200);
            5: t[2] = (k == 25) || (k == 35) || (k == 65)
                      || (k == 75) || (k == 85);
            default: t = '0;
        endcase
        return t;
    endfunction

    // open interval cyc: drive timebase and triggers at the falling edge
    task automatic step();
        @(negedge clk);
        khz  = khz_on && (phase < 10);
        trig = pat(mode, cyc);
        if (update === 1'b1) begin
            n_upd++;
            last_upd = cyc;
        end
        phase = (phase + 1) % 20;
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc <= n)
            step();
    endtask

    task automatic rd_chan(input int s);
        step();
        rd  = 1'b1;
        sel = SW'(s);
        step();
        rd  = 1'b0;
    endtask

    task automatic do_reset();
        khz_on = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        rd     = 1'b0;
        sel    = '0;
        period = '0;
        mode   = 0;
        phase  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic go(input int per, input int m);
        period   = PW'(per);
        mode     = m;
        khz_on   = 1'b1;
        phase    = 0;
        cyc      = 0;
        n_upd    = 0;
        last_upd = -1;
        step();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dat !== '0) $display("FAIL reset_dat got %0d want 0", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dat_valid);
        else passes++;
        checks++;
        if (update !== 1'b0) $display("FAIL reset_update got %b want 0", update);
        else passes++;
        checks++;
        if (overflow !== '0) $display("FAIL reset_ovf got %h want 0", overflow);
        else passes++;
        rd_chan(0);
        checks++;
        if (dat !== '0) $display("FAIL reset_rd_dat got %0d want 0", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b1) $display("FAIL reset_rd_valid got %b want 1", dat_valid);
        else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        go(4, 1);
        run_until(102);
        checks++;
        if (last_upd != 102) $display("FAIL basic_first_upd got %0d want 102", last_upd);
        else passes++;
        run_until(262);
        checks++;
        if (n_upd != 3) $display("FAIL basic_upd_count got %0d want 3", n_upd);
        else passes++;
        checks++;
        if (last_upd != 262) $display("FAIL basic_upd_period got %0d want 262", last_upd);
        else passes++;
        rd_chan(0);
        checks++;
        if (dat !== 16'd8) $display("FAIL basic_ch0 got %0d want 8", dat);
        else passes++;
        rd_chan(1);
        checks++;
        if (dat !== 16'd0) $display("FAIL basic_ch1 got %0d want 0", dat);
        else passes++;
        rd_chan(11);
        checks++;
        if (dat !== 16'd0) $display("FAIL basic_ch11 got %0d want 0", dat);
        else passes++;
        checks++;
        if (overflow !== '0) $display("FAIL basic_ovf got %h want 0", overflow);
        else passes++;
    endtask

    task automatic test_saturate();
        do_reset();
        go(4, 2);
        run_until(102);
        checks++;
        if (update4 !== 1'b1) $display("FAIL sat_update4 got %b want 1", update4);
        else passes++;
        checks++;
        if (overflow4 !== 12'h008) $display("FAIL sat_ovf4 got %h want 008", overflow4);
        else passes++;
        checks++;
        if (overflow !== '0) $display("FAIL sat_ovf16 got %h want 000", overflow);
        else passes++;
        rd_chan(3);
        checks++;
        if (dat4 !== 4'd15) $display("FAIL sat_ch3_cw4 got %0d want 15", dat4);
        else passes++;
        checks++;
        if (dat !== 16'd40) $display("FAIL sat_ch3_cw16 got %0d want 40", dat);
        else passes++;
        run_until(182);
        checks++;
        if (last_upd != 182) $display("FAIL sat_second_upd got %0d want 182", last_upd);
        else passes++;
        checks++;
        if (overflow4 !== '0) $display("FAIL sat_ovf4_clr got %h want 000", overflow4);
        else passes++;
        rd_chan(3);
        checks++;
        if (dat4 !== 4'd0) $display("FAIL sat_ch3_empty got %0d want 0", dat4);
        else passes++;
        checks++;
        if (dat_valid4 !== 1'b1) $display("FAIL sat_valid4 got %b want 1", dat_valid4);
        else passes++;
    endtask

    task automatic test_boundary();
        do_reset();
        go(2, 3);
        run_until(62);
        checks++;
        if (last_upd != 62) $display("FAIL bnd_upd1 got %0d want 62", last_upd);
        else passes++;
        rd_chan(1);
        checks++;
        if (dat !== 16'd2) $display("FAIL bnd_g1_ch1 got %0d want 2", dat);
        else passes++;
        rd_chan(2);
        checks++;
        if (dat !== 16'd0) $display("FAIL bnd_g1_ch2 got %0d want 0", dat);
        else passes++;
        run_until(102);
        checks++;
        if (last_upd != 102) $display("FAIL bnd_upd2 got %0d want 102", last_upd);
        else passes++;
        rd_chan(1);
        checks++;
        if (dat !== 16'd1) $display("FAIL bnd_g2_ch1 got %0d want 1", dat);
        else passes++;
        rd_chan(2);
        checks++;
        if (dat !== 16'd2) $display("FAIL bnd_g2_ch2 got %0d want 2", dat);
        else passes++;
        run_until(142);
        rd_chan(1);
        checks++;
        if (dat !== 16'd0) $display("FAIL bnd_g3_ch1 got %0d want 0", dat);
        else passes++;
        rd_chan(2);
        checks++;
        if (dat !== 16'd1) $display("FAIL bnd_g3_ch2 got %0d want 1", dat);
        else passes++;
    endtask

    task automatic test_clear();
        do_reset();
        go(4, 4);
        run_until(102);
        rd_chan(4);
        checks++;
        if (dat !== 16'd8) $display("FAIL clr_g1_ch4 got %0d want 8", dat);
        else passes++;
        run_until(154);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        run_until(159);
        rd_chan(4);
        checks++;
        if (dat !== 16'd8) $display("FAIL clr_bank_kept got %0d want 8", dat);
        else passes++;
        run_until(200);
        checks++;
        if (n_upd != 1) $display("FAIL clr_no_update got %0d want 1", n_upd);
        else passes++;
        run_until(242);
        checks++;
        if (last_upd != 242) $display("FAIL clr_regate_upd got %0d want 242", last_upd);
        else passes++;
        rd_chan(4);
        checks++;
        if (dat !== 16'd2) $display("FAIL clr_post_edges got %0d want 2", dat);
        else passes++;
    endtask

    task automatic test_read();
        do_reset();
        go(2, 5);
        run_until(100);
        step();
        rd  = 1'b1;
        sel = SW'(2);
        step();
        checks++;
        if (update !== 1'b1) $display("FAIL rdl_update got %b want 1", update);
        else passes++;
        checks++;
        if (dat !== 16'd2) $display("FAIL rdl_old got %0d want 2", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b1) $display("FAIL rdl_valid got %b want 1", dat_valid);
        else passes++;
        step();
        rd = 1'b0;
        checks++;
        if (dat !== 16'd3) $display("FAIL rdl_new got %0d want 3", dat);
        else passes++;
        step();
        checks++;
        if (dat !== 16'd3) $display("FAIL rdl_hold got %0d want 3", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b0) $display("FAIL rdl_pulse got %b want 0", dat_valid);
        else passes++;
        rd_chan(13);
        checks++;
        if (dat !== 16'd0) $display("FAIL rd_sel13 got %0d want 0", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b1) $display("FAIL rd_sel13_valid got %b want 1", dat_valid);
        else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        go(4, 1);
        run_until(110);
        rd_chan(0);
        checks++;
        if (dat !== 16'd8) $display("FAIL ares_pre got %0d want 8", dat);
        else passes++;
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dat !== '0) $display("FAIL ares_dat got %0d want 0", dat);
        else passes++;
        checks++;
        if (dat_valid !== 1'b0) $display("FAIL ares_valid got %b want 0", dat_valid);
        else passes++;
        period   = '0;
        mode     = 0;
        phase    = 3;
        cyc      = 0;
        n_upd    = 0;
        last_upd = -1;
        step();
        step();
        step();
        rst_n = 1'b1;
        run_until(38);
        checks++;
        if (n_upd != 0) $display("FAIL ares_spurious got %0d want 0", n_upd);
        else passes++;
        run_until(59);
        checks++;
        if (n_upd != 2) $display("FAIL ares_p0_count got %0d want 2", n_upd);
        else passes++;
        checks++;
        if (last_upd != 59) $display("FAIL ares_p0_upd got %0d want 59", last_upd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_boundary();
        test_clear();
        test_read();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
